// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK bit-splitter controller and its frame counter.
//   state_e         : controller FSM states
//   QPSK_BITS       : default bits per input byte
//   QPSK_NIB        : nibble width (one I or Q symbol group)
//   QPSK_FRAME_LEN  : default bytes per frame
package qpsk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } state_e;

    localparam int unsigned QPSK_BITS      = 8;
    localparam int unsigned QPSK_NIB       = QPSK_BITS / 2;
    localparam int unsigned QPSK_FRAME_LEN = 16;

endpackage

// File: rtl/qpsk_frame_cnt.sv
// Modulo-FRAME_LEN beat counter with start/end-of-frame decode.
// Shared by the transmit splitter controller and the receive-side deframer.
//   clk, rst : clock, synchronous active-high reset
//   inc      : advance the counter by one beat
//   cnt      : current position within the frame
//   sof      : position is the first beat of a frame
//   eof      : position is the last beat of a frame
module qpsk_frame_cnt
    import qpsk_pkg::*;
#(
    parameter int unsigned FRAME_LEN = QPSK_FRAME_LEN,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sof,
    output logic             eof
);

    localparam logic [CNT_W-1:0] Last = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sof = (cnt_q == '0);
    assign eof = (cnt_q == Last);

endmodule

// File: rtl/qpsk_split_ctrl.sv
// Sequencer for the QPSK bit-splitter datapath (byte PISO, even/odd toggle, dual SIPO).
// Accepts bytes over valid/ready, pulses the datapath load, counts out the serial shift and
// captures the even (I) / odd (Q) nibbles as one output beat tagged with frame markers.
//   clk, rst              : clock, synchronous active-high reset
//   in_data/valid/ready   : byte stream from the framer/FIFO
//   ld_o                  : one-cycle datapath load / toggle-reset pulse
//   dp_data_o             : byte presented to the datapath, registered at accept
//   sh_even_i, sh_odd_i   : splitter nibbles, sampled at the capture point
//   out_i/q/valid/ready   : symbol-group beat to the I/Q mapper
//   out_sof, out_eof      : beat is first / last of its frame
//   underrun, clr_err     : sticky mid-frame source stall flag and its clear
//   busy                  : a byte is being loaded or shifted
module qpsk_split_ctrl
    import qpsk_pkg::*;
#(
    parameter int unsigned BITS      = QPSK_BITS,
    parameter int unsigned CAP_DLY   = 8,
    parameter int unsigned FRAME_LEN = QPSK_FRAME_LEN,
    parameter int unsigned CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ld_o,
    input  logic [BITS/2-1:0] sh_even_i,
    input  logic [BITS/2-1:0] sh_odd_i,
    output logic [BITS-1:0]   dp_data_o,
    output logic [BITS/2-1:0] out_i,
    output logic [BITS/2-1:0] out_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              underrun,
    input  logic              clr_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CapLast = CNT_W'(CAP_DLY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [BITS-1:0]   dp_data_q;
    logic [BITS/2-1:0] out_i_q, out_q_q;
    logic              out_valid_q, out_sof_q, out_eof_q, underrun_q;

    logic              accept, capture, ur_set;
    logic [CNT_W-1:0]  frame_cnt;
    logic              frame_sof, frame_eof;

    qpsk_frame_cnt #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .inc (capture),
        .cnt (frame_cnt),
        .sof (frame_sof),
        .eof (frame_eof)
    );

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        ur_set      = 1'b0;
        ld_o        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only take a byte when the output slot is empty or draining this cycle, so the
                // coming capture can never overwrite an unconsumed beat.
                in_ready = !rst && (!out_valid_q || out_ready);
                accept   = in_valid && in_ready;
                ur_set   = (frame_cnt != '0) && !in_valid;
                if (accept) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ld_o        = 1'b1;
                shift_cnt_d = '0;
                state_d     = StShift;
            end
            StShift: begin
                shift_cnt_d = shift_cnt_q + CNT_W'(1);
                if (shift_cnt_q == CapLast) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_cnt_q <= '0;
            dp_data_q   <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            if (accept) begin
                dp_data_q <= in_data;
            end
            if (capture) begin
                out_i_q     <= sh_even_i;
                out_q_q     <= sh_odd_i;
                out_sof_q   <= frame_sof;
                out_eof_q   <= frame_eof;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Set dominates a simultaneous clear.
            underrun_q <= ur_set | (underrun_q & ~clr_err);
        end
    end

    assign dp_data_o = dp_data_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign underrun  = underrun_q;
    assign busy      = (state_q != StIdle);

endmodule
